// File: rtl/lcd_text_editor.sv
// lcd_text_editor: HD44780 8-bit text editor driven by digit and cursor keys.
//   clk, rst            : system clock, synchronous active-high reset
//   number_btn[9:0]     : digit keys 0..9 (level, synchronised)
//   control_btn[3:0]    : [0] right, [1] left, [2] newline, [3] backspace
//   LCD_E/RS/RW/DATA    : LCD bus (RW tied low)
//   LED_out[7:0]        : cursor linear position row*COLS+col
module lcd_text_editor #(
    parameter int COLS         = 16,
    parameter int ROWS         = 2,
    parameter int STEP_CYCLES  = 4000,
    parameter int INIT_CYCLES  = 400000,
    parameter int CURSOR_BLINK = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] number_btn,
    input  logic [3:0] control_btn,
    output logic       LCD_E,
    output logic       LCD_RS,
    output logic       LCD_RW,
    output logic [7:0] LCD_DATA,
    output logic [7:0] LED_out
);
    typedef enum logic [2:0] {
        POWER_WAIT, FUNC_SET, DISP_ONOFF, ENTRY_MODE, CLEAR, IDLE, SET_ADDR, WRITE
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic        row_q, row_d;
    logic [5:0]  col_q, col_d;
    logic [9:0]  num_prev_q;
    logic [3:0]  ctl_prev_q;
    logic [7:0]  char_q, char_d;
    logic        adv_q, adv_d;
    logic        bs_q, bs_d;
    logic        e_q, e_d, rs_q, rs_d;
    logic [7:0]  data_q, data_d, led_q, led_d;

    logic [9:0] num_rise;
    logic [3:0] ctl_rise;
    logic       digit_hit, done, nrow, fwd_row, bk_row;
    logic [3:0] digit;
    logic [5:0] fwd_col, bk_col;

    assign num_rise = number_btn & ~num_prev_q;
    assign ctl_rise = control_btn & ~ctl_prev_q;
    assign done     = cnt_q == STEP_CYCLES - 1;
    assign nrow     = ROWS == 2 ? ~row_q : 1'b0;
    assign fwd_col  = col_q == 6'(COLS - 1) ? 6'd0 : col_q + 6'd1;
    assign fwd_row  = col_q == 6'(COLS - 1) ? nrow : row_q;
    assign bk_col   = col_q == 6'd0 ? 6'(COLS - 1) : col_q - 6'd1;
    assign bk_row   = col_q == 6'd0 ? nrow : row_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 32'd1;
        row_d     = row_q;
        col_d     = col_q;
        char_d    = char_q;
        adv_d     = adv_q;
        bs_d      = bs_q;
        digit_hit = 1'b0;
        digit     = 4'd0;
        // Descending scan so the lowest-index digit wins.
        for (int i = 9; i >= 0; i--) begin
            if (num_rise[i]) begin
                digit_hit = 1'b1;
                digit     = 4'(i);
            end
        end
        case (state_q)
            POWER_WAIT: if (cnt_q == INIT_CYCLES - 1) begin
                state_d = FUNC_SET;
                cnt_d   = '0;
            end
            FUNC_SET: if (done) begin
                state_d = DISP_ONOFF;
                cnt_d   = '0;
            end
            DISP_ONOFF: if (done) begin
                state_d = ENTRY_MODE;
                cnt_d   = '0;
            end
            ENTRY_MODE: if (done) begin
                state_d = CLEAR;
                cnt_d   = '0;
            end
            CLEAR: if (done) begin
                state_d = IDLE;
                cnt_d   = '0;
                row_d   = 1'b0;
                col_d   = 6'd0;
            end
            IDLE: begin
                cnt_d = '0;
                if (ctl_rise[3]) begin
                    // Backspace at the origin is dropped, as are any other edges this cycle.
                    if ({row_q, col_q} != '0) begin
                        state_d = SET_ADDR;
                        row_d   = bk_row;
                        col_d   = bk_col;
                        bs_d    = 1'b1;
                    end
                end else if (ctl_rise[1]) begin
                    state_d = SET_ADDR;
                    row_d   = bk_row;
                    col_d   = bk_col;
                end else if (ctl_rise[0]) begin
                    state_d = SET_ADDR;
                    row_d   = fwd_row;
                    col_d   = fwd_col;
                end else if (ctl_rise[2]) begin
                    state_d = SET_ADDR;
                    row_d   = nrow;
                    col_d   = 6'd0;
                end else if (digit_hit) begin
                    state_d = WRITE;
                    char_d  = {4'h3, digit};
                    adv_d   = 1'b1;
                end
            end
            SET_ADDR: if (done) begin
                // A pending backspace inserts the blank write between two address steps.
                state_d = bs_q ? WRITE : IDLE;
                cnt_d   = '0;
                if (bs_q) begin
                    char_d = 8'h20;
                    adv_d  = 1'b0;
                    bs_d   = 1'b0;
                end
            end
            WRITE: if (done) begin
                state_d = SET_ADDR;
                cnt_d   = '0;
                if (adv_q) begin
                    row_d = fwd_row;
                    col_d = fwd_col;
                end
            end
        endcase
        // Bus outputs are registered copies of what the next state/cnt imply.
        e_d  = state_d != IDLE && state_d != POWER_WAIT && cnt_d >= 32'd1 && cnt_d <= STEP_CYCLES / 2;
        rs_d = state_d == WRITE;
        case (state_d)
            FUNC_SET:   data_d = ROWS == 2 ? 8'h38 : 8'h30;
            DISP_ONOFF: data_d = CURSOR_BLINK != 0 ? 8'h0F : 8'h0E;
            ENTRY_MODE: data_d = 8'h06;
            CLEAR:      data_d = 8'h01;
            SET_ADDR:   data_d = {1'b1, row_d, col_d};
            WRITE:      data_d = char_d;
            default:    data_d = 8'h00;
        endcase
        led_d = (row_d ? 8'(COLS) : 8'd0) + 8'(col_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= POWER_WAIT;
            cnt_q      <= '0;
            row_q      <= 1'b0;
            col_q      <= 6'd0;
            num_prev_q <= '0;
            ctl_prev_q <= '0;
            char_q     <= 8'h00;
            adv_q      <= 1'b0;
            bs_q       <= 1'b0;
            e_q        <= 1'b0;
            rs_q       <= 1'b0;
            data_q     <= 8'h00;
            led_q      <= 8'h00;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            row_q      <= row_d;
            col_q      <= col_d;
            num_prev_q <= number_btn;
            ctl_prev_q <= control_btn;
            char_q     <= char_d;
            adv_q      <= adv_d;
            bs_q       <= bs_d;
            e_q        <= e_d;
            rs_q       <= rs_d;
            data_q     <= data_d;
            led_q      <= led_d;
        end
    end

    assign LCD_E    = e_q;
    assign LCD_RS   = rs_q;
    assign LCD_RW   = 1'b0;
    assign LCD_DATA = data_q;
    assign LED_out  = led_q;
endmodule

// File: tb/tb_lcd_text_editor.sv
// tb_lcd_text_editor: scoreboarded bus-transaction and cursor-position checks.
module tb_lcd_text_editor;
    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] number_btn;
    logic [3:0] control_btn;
    logic       LCD_E, LCD_RS, LCD_RW;
    logic [7:0] LCD_DATA, LED_out;

    lcd_text_editor #(
        .COLS(16), .ROWS(2), .STEP_CYCLES(4), .INIT_CYCLES(8), .CURSOR_BLINK(1)
    ) dut (
        .clk(clk), .rst(rst), .number_btn(number_btn), .control_btn(control_btn),
        .LCD_E(LCD_E), .LCD_RS(LCD_RS), .LCD_RW(LCD_RW), .LCD_DATA(LCD_DATA), .LED_out(LED_out)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    logic [8:0] exp_q[$];

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Bus monitor: each E rising edge pops one expected {RS,DATA}; each pulse must be 2 cycles wide.
    logic e_prev = 1'b0;
    int   width  = 0;
    always @(negedge clk) begin
        if (LCD_E && !e_prev) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL bus: unexpected pulse RS=%0b DATA=0x%0h", LCD_RS, LCD_DATA);
            end else begin
                check("bus", {LCD_RS, LCD_DATA}, exp_q.pop_front());
            end
            width = 1;
        end else if (LCD_E) begin
            width++;
        end else if (e_prev && !rst) begin
            check("e_width", width, 2);
        end
        e_prev = LCD_E;
    end

    task automatic pulse(input logic [3:0] c, input logic [9:0] n);
        @(negedge clk);
        control_btn = c;
        number_btn  = n;
        @(negedge clk);
        control_btn = '0;
        number_btn  = '0;
    endtask

    task automatic settle();
        int n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("settle_queue", exp_q.size(), 0);
        exp_q.delete();
        repeat (6) @(negedge clk);
    endtask

    task automatic push_init();
        exp_q.push_back(9'h038);
        exp_q.push_back(9'h00F);
        exp_q.push_back(9'h006);
        exp_q.push_back(9'h001);
    endtask

    typedef struct {
        logic [3:0] ctl;
        logic [9:0] num;
        int         n;
        logic [8:0] b0, b1, b2;
        logic [7:0] led;
    } vec_t;
    localparam int NV = 20;
    vec_t vt[NV];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        vt[0]  = '{4'h0, 10'h200, 2, 9'h139, 9'h081, 9'h000, 8'd1};
        vt[1]  = '{4'h0, 10'h010, 2, 9'h134, 9'h082, 9'h000, 8'd2};
        vt[2]  = '{4'h8, 10'h000, 3, 9'h081, 9'h120, 9'h081, 8'd1};
        vt[3]  = '{4'h8, 10'h020, 3, 9'h080, 9'h120, 9'h080, 8'd0};
        vt[4]  = '{4'h8, 10'h000, 0, 9'h000, 9'h000, 9'h000, 8'd0};
        vt[5]  = '{4'h2, 10'h000, 1, 9'h0CF, 9'h000, 9'h000, 8'd31};
        vt[6]  = '{4'h1, 10'h000, 1, 9'h080, 9'h000, 9'h000, 8'd0};
        vt[7]  = '{4'h1, 10'h000, 1, 9'h081, 9'h000, 9'h000, 8'd1};
        vt[8]  = '{4'h4, 10'h000, 1, 9'h0C0, 9'h000, 9'h000, 8'd16};
        vt[9]  = '{4'h2, 10'h000, 1, 9'h08F, 9'h000, 9'h000, 8'd15};
        vt[10] = '{4'h1, 10'h000, 1, 9'h0C0, 9'h000, 9'h000, 8'd16};
        vt[11] = '{4'h7, 10'h000, 1, 9'h08F, 9'h000, 9'h000, 8'd15};
        vt[12] = '{4'h0, 10'h208, 2, 9'h133, 9'h0C0, 9'h000, 8'd16};
        vt[13] = '{4'h4, 10'h000, 1, 9'h080, 9'h000, 9'h000, 8'd0};
        vt[14] = '{4'h0, 10'h001, 2, 9'h130, 9'h081, 9'h000, 8'd1};
        vt[15] = '{4'h0, 10'h004, 2, 9'h132, 9'h082, 9'h000, 8'd2};
        vt[16] = '{4'h0, 10'h080, 2, 9'h137, 9'h083, 9'h000, 8'd3};
        vt[17] = '{4'h8, 10'h000, 3, 9'h082, 9'h120, 9'h082, 8'd2};
        vt[18] = '{4'h2, 10'h000, 1, 9'h081, 9'h000, 9'h000, 8'd1};
        vt[19] = '{4'h2, 10'h000, 1, 9'h080, 9'h000, 9'h000, 8'd0};

        rst = 1'b1;
        number_btn  = '0;
        control_btn = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_e", LCD_E, 0);
        check("rst_rs", LCD_RS, 0);
        check("rst_rw", LCD_RW, 0);
        check("rst_data", LCD_DATA, 0);
        check("rst_led", LED_out, 0);

        push_init();
        rst = 1'b0;
        n = 0;
        while (!LCD_E && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("power_wait", n, 9);
        settle();
        check("idle_led", LED_out, 0);
        check("idle_rs", LCD_RS, 0);
        check("idle_data", LCD_DATA, 0);

        for (int i = 0; i < NV; i++) begin
            if (vt[i].n > 0) exp_q.push_back(vt[i].b0);
            if (vt[i].n > 1) exp_q.push_back(vt[i].b1);
            if (vt[i].n > 2) exp_q.push_back(vt[i].b2);
            pulse(vt[i].ctl, vt[i].num);
            settle();
            check($sformatf("led_vec%0d", i), LED_out, vt[i].led);
        end

        // Sixteen writes fill row 0 and land the cursor at (1,0).
        for (int i = 0; i < 16; i++) begin
            exp_q.push_back({1'b1, 4'h3, 4'(i % 10)});
            exp_q.push_back(i == 15 ? 9'h0C0 : 9'(9'h080 + i + 1));
            pulse(4'h0, 10'(1 << (i % 10)));
            settle();
        end
        check("led_fill", LED_out, 16);
        exp_q.push_back(9'h080);
        pulse(4'h4, 10'h000);
        settle();
        check("led_newline", LED_out, 0);

        // A digit edge arriving mid-step is dropped.
        exp_q.push_back(9'h131);
        exp_q.push_back(9'h081);
        pulse(4'h0, 10'h002);
        @(negedge clk);
        pulse(4'h0, 10'h020);
        settle();
        check("led_busy_drop", LED_out, 1);

        // Reset while E is high in WRITE restarts the init sequence.
        exp_q.push_back(9'h136);
        pulse(4'h0, 10'h040);
        n = 0;
        while (!LCD_E && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("write_e_seen", LCD_E, 1);
        check("write_rs", LCD_RS, 1);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_e", LCD_E, 0);
        check("midrst_led", LED_out, 0);
        push_init();
        @(negedge clk);
        rst = 1'b0;
        settle();
        check("reinit_led", LED_out, 0);
        exp_q.push_back(9'h139);
        exp_q.push_back(9'h081);
        pulse(4'h0, 10'h200);
        settle();
        check("post_reinit_led", LED_out, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/lcd_text_editor.md
LCD_TEXT_EDITOR -- requirements
Module: lcd_text_editor

Interface
REQ-001 SHALL have parameter COLS, default 16, characters per LCD row (1..64).
REQ-002 SHALL have parameter ROWS, default 2, LCD rows used (1 or 2); ROWS*COLS <= 128.
REQ-003 SHALL have parameter STEP_CYCLES, default 4000, clk cycles per LCD bus step (even, >= 4).
REQ-004 SHALL have parameter INIT_CYCLES, default 400000, clk cycles of power-up wait.
REQ-005 SHALL have parameter CURSOR_BLINK, default 1, 1 = cursor + blink on, 0 = cursor on, no blink.
REQ-006 clk  input  1  system clock; single clock domain, all logic on rising edge.
REQ-007 rst  input  1  reset, synchronous, active-high.
REQ-008 number_btn  input  10  digit keys 0..9, level, already synchronised.
REQ-009 control_btn  input  4  [0] right, [1] left, [2] newline, [3] backspace.
REQ-010 LCD_E  output  1  HD44780 enable strobe.
REQ-011 LCD_RS  output  1  0 = command, 1 = data.
REQ-012 LCD_RW  output  1  tied 0 (write only).
REQ-013 LCD_DATA  output  8  LCD data bus.
REQ-014 LED_out  output  8  cursor linear position row*COLS+col, zero-extended.

Function
REQ-015 SHALL have states POWER_WAIT, FUNC_SET, DISP_ONOFF, ENTRY_MODE, CLEAR, IDLE, SET_ADDR, WRITE.
REQ-016 POWER_WAIT SHALL last INIT_CYCLES cycles with LCD_E=0, then go to FUNC_SET.
REQ-017 Every other non-IDLE state is one step: counter cnt runs 0..STEP_CYCLES-1; LCD_RS/LCD_DATA held for the entire step; LCD_E=1 only for cnt in 1..STEP_CYCLES/2; state advances when cnt = STEP_CYCLES-1, and cnt then restarts at 0.
REQ-018 Init bytes (RS=0): FUNC_SET 0x38 (ROWS=2) / 0x30 (ROWS=1); DISP_ONOFF 0x0F (CURSOR_BLINK=1) / 0x0E; ENTRY_MODE 0x06; CLEAR 0x01; then IDLE with cursor (0,0).
REQ-019 In IDLE: LCD_E=0, LCD_RS=0, LCD_DATA=0x00.
REQ-020 Key events SHALL be rising edges (btn & ~btn_prev, btn_prev registered every cycle); edges arriving outside IDLE are discarded, not queued.
REQ-021 Simultaneous edges: one event only; priority backspace > left > right > newline > lowest-index digit.
REQ-022 Event accepted in IDLE cycle N SHALL put the FSM in its first step state with cnt=0 at cycle N+1.
REQ-023 Digit d: WRITE (RS=1, data 0x30+d) at current cursor; cursor advances at step end; then SET_ADDR; then IDLE.
REQ-024 Right / left / newline: cursor updated at acceptance; then SET_ADDR; then IDLE.
REQ-025 Backspace at a cursor other than (0,0): cursor moves left at acceptance; SET_ADDR, WRITE 0x20 (cursor unchanged), SET_ADDR; then IDLE.
REQ-026 Backspace at (0,0) SHALL be ignored: no bus traffic, FSM stays in IDLE.
REQ-027 SET_ADDR SHALL drive RS=0, data 0x80 | (row*0x40 + col), using the cursor value current at that step.
REQ-028 Advance / right: col+1; at col=COLS-1, col=0 and row=(row+1) mod ROWS; (ROWS-1,COLS-1) wraps to (0,0).
REQ-029 Left: col-1; at col=0, col=COLS-1 and row=row-1; (0,0) wraps to (ROWS-1,COLS-1).
REQ-030 Newline: col=0, row=(row+1) mod ROWS.
REQ-031 LED_out SHALL update in the same cycle as the cursor register.

Reset
REQ-032 While rst=1 at a clock edge: state=POWER_WAIT, cnt=0, cursor=(0,0), btn_prev=0, LCD_E=0, LCD_RS=0, LCD_RW=0, LCD_DATA=0x00, LED_out=0x00.
REQ-033 rst asserted mid-step (including while LCD_E=1) SHALL force LCD_E=0 at the next edge and restart the full init sequence; no partial event completes.

Verification (COLS=16, ROWS=2, STEP_CYCLES=4, INIT_CYCLES=8)
REQ-034 Release reset -> 8 cycles E=0, then four E pulses with RS=0, data 0x38, 0x0F, 0x06, 0x01, each 2 cycles wide; IDLE; LED_out=0.
REQ-035 number_btn[9] 1-cycle pulse in IDLE -> WRITE RS=1 0x39, SET_ADDR 0x81, LED_out=1; then number_btn[4] -> 0x34, 0x82, LED_out=2.
REQ-036 control_btn[1] at (0,0) -> SET_ADDR 0xCF, LED_out=31; then control_btn[0] -> 0x80, LED_out=0.
REQ-037 16 digit writes from (0,0) -> final SET_ADDR 0xC0, LED_out=16; then newline -> 0x80, LED_out=0.
REQ-038 Backspace at (0,3) -> 0x82, RS=1 0x20, 0x82, LED_out=2; backspace at (0,0) -> no E pulse; backspace + digit same cycle -> only the backspace sequence; digit pulse during a step -> ignored.
REQ-039 rst pulse while LCD_E=1 in WRITE -> LCD_E=0 next cycle, LED_out=0, init sequence of REQ-034 repeats.
